// File: rtl/fwd_scoreboard.sv
// Forwarding select and hazard controller between decode and execute.
// Tracks outstanding long-latency writebacks in a per-register scoreboard.
module fwd_scoreboard #(
    parameter int N_FWD    = 3,
    parameter int REG_W    = 5,
    parameter int MAX_OUT  = 4,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(N_FWD + 1),
    parameter int NUM_REGS = 2 ** REG_W,
    parameter int OCW      = $clog2(MAX_OUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_valid,
    input  logic [REG_W-1:0]       d_rs1,
    input  logic [REG_W-1:0]       d_rs2,
    input  logic                   d_rs1_used,
    input  logic                   d_rs2_used,
    input  logic [REG_W-1:0]       d_rd,
    input  logic                   d_long,
    input  logic                   flush,
    input  logic [N_FWD-1:0]       stage_wen,
    input  logic [N_FWD*REG_W-1:0] stage_rd,
    input  logic [N_FWD-1:0]       stage_ready,
    input  logic                   cpl_valid,
    input  logic [REG_W-1:0]       cpl_rd,
    output logic                   stall,
    output logic [SEL_W-1:0]       x_rs1_sel,
    output logic [SEL_W-1:0]       x_rs2_sel,
    output logic [NUM_REGS-1:0]    pending,
    output logic [OCW-1:0]         out_cnt,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic                   cpl_err
);

    logic [SEL_W:0]   res1;
    logic [SEL_W:0]   res2;
    logic             waw_haz;
    logic             cap_haz;
    logic             issue;
    logic             cpl_ok;
    logic             long_issue;
    logic [REG_W:0]   pop;

    // Returns {hazard, select}; lowest matching stage (youngest) wins.
    function automatic logic [SEL_W:0] resolve(
        input logic [REG_W-1:0] src,
        input logic             used
    );
        logic             hit;
        logic [SEL_W-1:0] sel;
        logic             haz;
        hit = 1'b0;
        sel = '0;
        haz = 1'b0;
        if (used && src != '0) begin
            for (int k = 0; k < N_FWD; k++) begin
                if (!hit && stage_wen[k] && stage_rd[k*REG_W +: REG_W] == src) begin
                    hit = 1'b1;
                    sel = SEL_W'(k + 1);
                    haz = !stage_ready[k];
                end
            end
            if (!hit) haz = pending[src];
        end
        return {haz, sel};
    endfunction

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_REGS; i++) pop = pop + (REG_W+1)'(pending[i]);
    end

    always_comb begin
        res1    = resolve(d_rs1, d_rs1_used);
        res2    = resolve(d_rs2, d_rs2_used);
        waw_haz = d_long && d_rd != '0 && pending[d_rd];
        cap_haz = d_long && out_cnt == OCW'(MAX_OUT);
        stall   = d_valid && !flush &&
                  (res1[SEL_W] || res2[SEL_W] || waw_haz || cap_haz);
        issue   = d_valid && !stall && !flush;
        long_issue = issue && d_long;
        // x0 completions belong to long ops with rd=x0, which hold no pending bit.
        if (cpl_rd != '0)
            cpl_ok = cpl_valid && pending[cpl_rd];
        else
            cpl_ok = cpl_valid && (int'(out_cnt) > int'(pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_rs1_sel    <= '0;
            x_rs2_sel    <= '0;
            pending      <= '0;
            out_cnt      <= '0;
            stall_cycles <= '0;
            cpl_err      <= 1'b0;
        end else begin
            x_rs1_sel <= issue ? res1[SEL_W-1:0] : '0;
            x_rs2_sel <= issue ? res2[SEL_W-1:0] : '0;
            if (long_issue && d_rd != '0) pending[d_rd] <= 1'b1;
            if (cpl_ok && cpl_rd != '0) pending[cpl_rd] <= 1'b0;
            if (long_issue && !cpl_ok && out_cnt != OCW'(MAX_OUT))
                out_cnt <= out_cnt + 1'b1;
            else if (!long_issue && cpl_ok && out_cnt != '0)
                out_cnt <= out_cnt - 1'b1;
            if (stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (cpl_valid && !cpl_ok) cpl_err <= 1'b1;
        end
    end

endmodule
